// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding (also used by the master's
// debug decode), default target address and ACK/NACK bus levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_e;

    localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h18;
    localparam logic       I2C_ACK              = 1'b0;
    localparam logic       I2C_NACK             = 1'b1;

    // Zero-extended state for the 8-bit debug port.
    function automatic logic [7:0] state_debug(input i2c_state_e s);
        return {4'b0000, s};
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the sampling clock domain and derives
// single-cycle scl_rise/scl_fall and START/STOP condition pulses.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk_100k,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0] first sync stage, [1] synchronised level, [2] previous level
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;

    // Next values of the synchroniser/edge-detect shift chains.
    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_i};
        sda_pipe_d = {sda_pipe_q[1:0], sda_i};
    end

    // Synchroniser flops; reset to the idle (released, high) bus level.
    always_ff @(posedge clk_100k) begin
        if (reset) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    assign sda_s     = sda_pipe_q[1];
    assign scl_rise  = scl_pipe_q[1] & ~scl_pipe_q[2];
    assign scl_fall  = ~scl_pipe_q[1] & scl_pipe_q[2];
    assign start_det = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[2] & ~sda_pipe_q[1];
    assign stop_det  = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[2] & sda_pipe_q[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target responder with an inline 8-bit register file. Supports
// register-pointer writes with auto-increment bursts and pointer reads
// (with repeated START). SDA is only ever pulled low, never driven high.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR_DEFAULT,
    parameter int         NREGS    = 16,
    parameter int         PTR_W    = 4
) (
    input  logic             clk_100k,
    input  logic             reset,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] loc_addr,
    output logic [7:0]       loc_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic [7:0]       i2c_state
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk_100k  (clk_100k),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;

    logic [7:0]       regs_q [NREGS];
    logic             reg_we_s;
    logic [7:0]       reg_wdata_s;
    logic [7:0]       shift_in_s;
    logic [7:0]       cur_reg_s;

    assign shift_in_s = {shift_q[6:0], sda_s};
    assign cur_reg_s  = regs_q[ptr_q];

    // Next-state and output logic; START/STOP override any scl edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we_s    = 1'b0;
        reg_wdata_s = shift_in_s;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d  = ST_WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q == 1'b0) begin
                            state_d   = ST_REG;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            // First read bit goes out right as the ACK clock ends.
                            state_d   = ST_RDATA;
                            shift_d   = cur_reg_s;
                            sda_oe_d  = ~cur_reg_s[7];
                            bit_cnt_d = 4'd1;
                        end
                    end else begin
                        state_d = ST_ADDR_ACK;
                    end
                end
                ST_REG: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        ptr_d    = shift_q[PTR_W-1:0];
                        sda_oe_d = 1'b1;
                        state_d  = ST_REG_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_REG_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WDATA;
                    end else begin
                        state_d = ST_REG_ACK;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Commit on the 8th data bit; the strobe follows one cycle later.
                        if (bit_cnt_q == 4'd7) begin
                            reg_we_s    = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = shift_in_s;
                        end else begin
                            reg_we_s = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = ST_WDATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        ptr_d     = ptr_q + PTR_W'(1);
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WDATA;
                    end else begin
                        state_d = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            ptr_d = ptr_q + PTR_W'(1);
                        end
                    end else if (scl_fall) begin
                        shift_d   = cur_reg_s;
                        sda_oe_d  = ~cur_reg_s[7];
                        bit_cnt_d = 4'd1;
                        state_d   = ST_RDATA;
                    end else begin
                        state_d = ST_RDATA_ACK;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // Control/status flops.
    always_ff @(posedge clk_100k) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file: cleared on reset, written from the bus at the pointer.
    always_ff @(posedge clk_100k) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (reg_we_s) begin
            regs_q[ptr_q] <= reg_wdata_s;
        end
    end

    assign loc_rdata = regs_q[loc_addr];
    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign i2c_state = state_debug(state_q);

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged bus master drives
// table-driven single-byte writes plus hand-written burst, read,
// aborted-write and reset-during-read sequences.
module tb_i2c_target_regs;

    logic       clk_100k = 1'b0;
    logic       reset    = 1'b1;
    logic       scl_m    = 1'b1;
    logic       sda_m    = 1'b1;
    logic       sda_oe;
    logic       sda_line;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] i2c_state;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs dut (
        .clk_100k  (clk_100k),
        .reset     (reset),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .i2c_state (i2c_state)
    );

    always #5 clk_100k = ~clk_100k;

    always @(negedge clk_100k) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        repeat (60000) @(posedge clk_100k);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (4) @(negedge clk_100k);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_q();
            scl_m = 1'b1; wait_q(); wait_q();
            scl_m = 1'b0; wait_q();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        write_bits(b, 8);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = sda_line;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl_m = 1'b1; wait_q();
            b[i] = sda_line;
            wait_q();
            scl_m = 1'b0; wait_q();
        end
        sda_m = mack; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic loc_read(input logic [3:0] a, output logic [7:0] v);
        loc_addr = a;
        #1;
        v = loc_rdata;
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] regb;
        logic [7:0] data;
        logic       exp_ack;
        logic [3:0] chk_idx;
        logic [7:0] exp_val;
        int         exp_strobes;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic [7:0] v;
        int         s0;
        int         bad;

        vecs[0] = '{dev: 8'h30, regb: 8'h05, data: 8'hA7, exp_ack: 1'b0, chk_idx: 4'd5, exp_val: 8'hA7, exp_strobes: 1};
        vecs[1] = '{dev: 8'h32, regb: 8'h05, data: 8'h55, exp_ack: 1'b1, chk_idx: 4'd5, exp_val: 8'hA7, exp_strobes: 0};
        vecs[2] = '{dev: 8'h00, regb: 8'h05, data: 8'h55, exp_ack: 1'b1, chk_idx: 4'd5, exp_val: 8'hA7, exp_strobes: 0};
        vecs[3] = '{dev: 8'h30, regb: 8'h23, data: 8'h5C, exp_ack: 1'b0, chk_idx: 4'd3, exp_val: 8'h5C, exp_strobes: 1};

        repeat (4) @(negedge clk_100k);
        reset = 1'b0;
        @(negedge clk_100k);

        // Reset state
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_state", 32'(i2c_state), 32'd0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            loc_read(4'(i), v);
            if (v !== 8'h00) bad++;
        end
        chk("rst_regs_nonzero", 32'(bad), 32'd0);

        // Table-driven single-byte write transactions
        for (int i = 0; i < 4; i++) begin
            s0 = strobe_cnt;
            i2c_start();
            write_byte(vecs[i].dev, ack);
            chk("addr_ack", 32'(ack), 32'(vecs[i].exp_ack));
            if (vecs[i].exp_ack == 1'b0) begin
                chk("busy_matched", 32'(busy), 32'd1);
                write_byte(vecs[i].regb, ack);
                chk("reg_ack", 32'(ack), 32'd0);
                write_byte(vecs[i].data, ack);
                chk("data_ack", 32'(ack), 32'd0);
                chk("wr_addr", 32'(wr_addr), 32'(vecs[i].regb[3:0]));
                chk("wr_data", 32'(wr_data), 32'(vecs[i].data));
            end else begin
                chk("busy_unmatched", 32'(busy), 32'd0);
            end
            i2c_stop();
            chk("strobes", 32'(strobe_cnt - s0), 32'(vecs[i].exp_strobes));
            chk("state_idle", 32'(i2c_state), 32'd0);
            chk("busy_after_stop", 32'(busy), 32'd0);
            loc_read(vecs[i].chk_idx, v);
            chk("loc_rdata", 32'(v), 32'(vecs[i].exp_val));
        end

        // Burst write across the pointer wrap
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h30, ack);
        write_byte(8'h0E, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        write_byte(8'h33, ack);
        chk("burst_last_ack", 32'(ack), 32'd0);
        i2c_stop();
        chk("burst_strobes", 32'(strobe_cnt - s0), 32'd3);
        loc_read(4'd14, v); chk("burst_r14", 32'(v), 32'h11);
        loc_read(4'd15, v); chk("burst_r15", 32'(v), 32'h22);
        loc_read(4'd0, v);  chk("burst_r0", 32'(v), 32'h33);

        // Pointer write, repeated START, read with ACK then NACK
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h30, ack);
        write_byte(8'h05, ack);
        i2c_start();
        write_byte(8'h31, ack);
        chk("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(rb, 1'b0);
        chk("rd_byte0", 32'(rb), 32'hA7);
        read_byte(rb, 1'b1);
        chk("rd_byte1", 32'(rb), 32'h00);
        chk("rd_wait_stop", 32'(i2c_state), 32'd9);
        chk("rd_released", 32'(sda_oe), 32'd0);
        i2c_stop();
        chk("rd_idle", 32'(i2c_state), 32'd0);
        chk("rd_no_strobe", 32'(strobe_cnt - s0), 32'd0);

        // STOP after 4 data bits aborts the write
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h30, ack);
        write_byte(8'h07, ack);
        write_bits(8'hA0, 4);
        i2c_stop();
        chk("abort_idle", 32'(i2c_state), 32'd0);
        chk("abort_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        loc_read(4'd7, v); chk("abort_r7", 32'(v), 32'h00);
        i2c_start();
        write_byte(8'h30, ack);
        chk("after_abort_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h07, ack);
        write_byte(8'h3C, ack);
        chk("after_abort_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        loc_read(4'd7, v); chk("after_abort_r7", 32'(v), 32'h3C);

        // Reset while the target pulls SDA low during a read
        i2c_start();
        write_byte(8'h30, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'h31, ack);
        repeat (2) @(negedge clk_100k);
        chk("pre_rst_state", 32'(i2c_state), 32'd7);
        chk("pre_rst_drive", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        @(posedge clk_100k);
        #1;
        chk("rst_release_sda", 32'(sda_oe), 32'd0);
        @(negedge clk_100k);
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (8) @(negedge clk_100k);
        chk("post_rst_state", 32'(i2c_state), 32'd0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            loc_read(4'(i), v);
            if (v !== 8'h00) bad++;
        end
        chk("post_rst_regs_nonzero", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
